// File: rtl/color_subcarrier_dds.sv
// Colour-subcarrier NCO: 4x subcarrier square wave from a phase accumulator on mcolorclk.
// Tuning-word changes are deferred to accumulator wrap so the output stays phase-continuous.
module color_subcarrier_dds #(
  parameter int unsigned      ACC_W    = 32,
  parameter logic [ACC_W-1:0] INC_PAL  = ACC_W'(761689901),
  parameter logic [ACC_W-1:0] INC_NTSC = ACC_W'(614961234),
  parameter logic [ACC_W-1:0] INC_PALN = ACC_W'(615553001),
  parameter logic [ACC_W-1:0] INC_PALM = ACC_W'(614310196)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             altern,
  output logic             clkcolor4x,
  output logic             rise_stb,
  output logic [ACC_W-1:0] inc_active
);

  typedef enum logic {IDLE, RUN} state_e;

  logic             en_meta_q, en_sync_q;
  logic             mode_meta_q, mode_sync_q;
  logic             alt_meta_q, alt_sync_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic             clk4x_q, clk4x_d;
  logic             rise_q, rise_d;
  logic [ACC_W-1:0] sel_word;
  logic [ACC_W:0]   sum;
  state_e           state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_meta_q   <= 1'b0;
      en_sync_q   <= 1'b0;
      mode_meta_q <= 1'b1;
      mode_sync_q <= 1'b1;
      alt_meta_q  <= 1'b0;
      alt_sync_q  <= 1'b0;
    end else begin
      en_meta_q   <= enable;
      en_sync_q   <= en_meta_q;
      mode_meta_q <= mode;
      mode_sync_q <= mode_meta_q;
      alt_meta_q  <= altern;
      alt_sync_q  <= alt_meta_q;
    end
  end

  always_comb begin
    sel_word = INC_PAL;
    case ({mode_sync_q, alt_sync_q})
      2'b10:   sel_word = INC_PAL;
      2'b11:   sel_word = INC_PALN;
      2'b00:   sel_word = INC_NTSC;
      default: sel_word = INC_PALM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      inc_q   <= INC_PAL;
      clk4x_q <= 1'b1;
      rise_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      clk4x_q <= clk4x_d;
      rise_q  <= rise_d;
    end
  end

  always_comb begin
    state   = en_sync_q ? RUN : IDLE;
    sum     = {1'b0, acc_q} + {1'b0, inc_q};
    acc_d   = acc_q;
    inc_d   = inc_q;
    clk4x_d = clk4x_q;
    rise_d  = 1'b0;
    case (state)
      IDLE: begin
        acc_d   = '0;
        inc_d   = sel_word;
        clk4x_d = 1'b1;
      end
      RUN: begin
        acc_d   = sum[ACC_W-1:0];
        clk4x_d = acc_q[ACC_W-1];
        rise_d  = acc_q[ACC_W-1] & ~clk4x_q;
        // Word swap only on carry-out keeps the phase continuous.
        if (sum[ACC_W]) inc_d = sel_word;
      end
      default: ;
    endcase
  end

  assign clkcolor4x = clk4x_q;
  assign rise_stb   = rise_q;
  assign inc_active = inc_q;

endmodule

// File: tb/tb_color_subcarrier_dds.sv
// Self-checking bench for color_subcarrier_dds: per-cycle model comparison plus directed literal checks.
`timescale 1ns/1ps
module tb_color_subcarrier_dds;

  localparam longint unsigned W_PAL  = 761689901;
  localparam longint unsigned W_NTSC = 614961234;
  localparam longint unsigned W_PALN = 615553001;
  localparam longint unsigned W_PALM = 614310196;
  localparam longint unsigned MOD    = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b1;
  logic        altern = 1'b0;
  logic        clkcolor4x;
  logic        rise_stb;
  logic [31:0] inc_active;

  int n_checks = 0;
  int n_fail   = 0;

  color_subcarrier_dds #(.ACC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .altern(altern),
    .clkcolor4x(clkcolor4x), .rise_stb(rise_stb), .inc_active(inc_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  function automatic longint unsigned word_for(input logic m, input logic a);
    if (m && !a)  return W_PAL;
    if (m && a)   return W_PALN;
    if (!m && !a) return W_NTSC;
    return W_PALM;
  endfunction

  // Model: inputs seen by the oscillator are the pin values two edges earlier;
  // the phase is a plain integer modulo 2^32 and the output is its top half.
  logic             h_en [2];
  logic             h_md [2];
  logic             h_al [2];
  longint unsigned  m_phase, m_inc;
  logic             m_clk, m_rise;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_en[0] = 1'b0; h_en[1] = 1'b0;
      h_md[0] = 1'b1; h_md[1] = 1'b1;
      h_al[0] = 1'b0; h_al[1] = 1'b0;
      m_phase = 0; m_inc = W_PAL; m_clk = 1'b1; m_rise = 1'b0;
    end else begin
      logic             en_v, md_v, al_v, new_clk;
      longint unsigned  next_phase;
      en_v = h_en[1]; md_v = h_md[1]; al_v = h_al[1];
      h_en[1] = h_en[0]; h_md[1] = h_md[0]; h_al[1] = h_al[0];
      h_en[0] = enable;  h_md[0] = mode;    h_al[0] = altern;
      if (!en_v) begin
        m_phase = 0; m_clk = 1'b1; m_rise = 1'b0; m_inc = word_for(md_v, al_v);
      end else begin
        new_clk    = (m_phase >= MOD / 2);
        m_rise     = new_clk && !m_clk;
        m_clk      = new_clk;
        next_phase = m_phase + m_inc;
        if (next_phase >= MOD) m_inc = word_for(md_v, al_v);
        m_phase    = next_phase % MOD;
      end
    end
  end

  bit cmp_on = 1'b0;
  bit dur_on = 1'b0;
  int dur_min = 2, dur_max = 3;
  bit dur_arm = 1'b0;
  int run_len = 0;
  logic prev_clk = 1'b1;

  always @(posedge clk) begin
    #1;
    if (cmp_on && rst_n) begin
      check("clkcolor4x", clkcolor4x, m_clk);
      check("rise_stb", rise_stb, m_rise);
      check("inc_active", inc_active, m_inc);
    end
    if (dur_on) begin
      if (clkcolor4x === prev_clk) run_len++;
      else begin
        if (dur_arm) check_range("hilo_time", run_len, dur_min, dur_max);
        dur_arm = 1'b1;
        run_len = 1;
      end
    end else begin
      dur_arm = 1'b0;
      run_len = 0;
    end
    prev_clk = clkcolor4x;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_inc(input string name, input longint unsigned exp);
    int k = 0;
    while (inc_active != exp[31:0] && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, inc_active, exp);
  endtask

  task automatic count_rises(input string name, input int n, input longint unsigned w);
    int cnt = 0;
    longint nominal;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rise_stb) cnt++;
    end
    nominal = longint'((longint'(n) * w) / MOD);
    check_range(name, cnt, nominal - 1, nominal + 1);
  endtask

  initial begin
    // 1: reset and idle
    #23;
    check("reset_clk", clkcolor4x, 1);
    check("reset_rise", rise_stb, 0);
    check("reset_inc", inc_active, 761689901);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_on = 1'b1;
    cyc(100);
    check("idle_clk", clkcolor4x, 1);
    check("idle_inc", inc_active, 761689901);

    // 2: PAL run
    enable = 1'b1;
    cyc(20);
    dur_min = 2; dur_max = 3; dur_on = 1'b1;
    count_rises("pal_rises", 10000, W_PAL);

    // 3: PAL -> NTSC at wrap
    dur_min = 2; dur_max = 4;
    mode = 1'b0;
    wait_inc("ntsc_word", 614961234);
    cyc(20);
    dur_min = 3; dur_max = 4;
    count_rises("ntsc_rises", 10000, W_NTSC);
    dur_on = 1'b0;

    // 4: PAL-N then PAL-M
    mode = 1'b1; altern = 1'b1;
    wait_inc("paln_word", 615553001);
    cyc(30);
    mode = 1'b0; altern = 1'b1;
    wait_inc("palm_word", 614310196);
    cyc(13);

    // 5: disable mid-period, then re-enable
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("disable_clk_3clk", clkcolor4x, 1);
    check("disable_rise", rise_stb, 0);
    cyc(10);
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reen_still_high", clkcolor4x, 1);
    @(posedge clk);
    #1;
    check("reen_falls", clkcolor4x, 0);
    begin
      int k = 0;
      while (!rise_stb && k < 50) begin
        @(negedge clk);
        k++;
      end
      check("first_rise_seen", rise_stb, 1);
      check("first_rise_clk", clkcolor4x, 1);
    end
    cyc(40);

    // 6: short async reset mid-run
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #0.5;
    check("areset_clk", clkcolor4x, 1);
    check("areset_rise", rise_stb, 0);
    check("areset_inc", inc_active, 761689901);
    #0.5;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("resync_idle", clkcolor4x, 1);
    cyc(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
